// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU opcodes, MIPS op/funct fields, field widths.
package alu_pkg;

    localparam int NB_SHAMT = 5;
    localparam int NB_IMM   = 16;

    localparam logic [3:0] ALU_SLL = 4'b0000;
    localparam logic [3:0] ALU_SRL = 4'b0010;
    localparam logic [3:0] ALU_SRA = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1001;
    localparam logic [3:0] ALU_SUB = 4'b1011;
    localparam logic [3:0] ALU_ADD = 4'b1100;
    localparam logic [3:0] ALU_OR  = 4'b1101;
    localparam logic [3:0] ALU_XOR = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode: instruction + register operands -> ALU opcode, signed flag, operands.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int NB_DATA       = 32,
    parameter int NB_ALU_OPCODE = 4
) (
    input  logic [NB_DATA-1:0]       i_instruction,
    input  logic [NB_DATA-1:0]       i_rs_data,
    input  logic [NB_DATA-1:0]       i_rt_data,
    output logic [NB_ALU_OPCODE-1:0] o_opcode,
    output logic                     o_signed,
    output logic [NB_DATA-1:0]       o_first,
    output logic [NB_DATA-1:0]       o_second,
    output logic                     o_illegal
);

    logic [5:0]         w_op;
    logic [5:0]         w_funct;
    logic [NB_DATA-1:0] w_shamt;
    logic [NB_DATA-1:0] w_rs_shamt;
    logic [NB_DATA-1:0] w_imm_sext;
    logic [NB_DATA-1:0] w_imm_zext;
    logic [NB_DATA-1:0] w_imm_upper;
    logic [3:0]         w_code;
    logic               w_unused_regidx;

    assign w_op        = i_instruction[31:26];
    assign w_funct     = i_instruction[5:0];
    assign w_shamt     = {{(NB_DATA-NB_SHAMT){1'b0}}, i_instruction[10:6]};
    assign w_rs_shamt  = {{(NB_DATA-NB_SHAMT){1'b0}}, i_rs_data[NB_SHAMT-1:0]};
    assign w_imm_sext  = {{(NB_DATA-NB_IMM){i_instruction[NB_IMM-1]}}, i_instruction[NB_IMM-1:0]};
    assign w_imm_zext  = {{(NB_DATA-NB_IMM){1'b0}}, i_instruction[NB_IMM-1:0]};
    assign w_imm_upper = {i_instruction[NB_IMM-1:0], {(NB_DATA-NB_IMM){1'b0}}};
    // Register indices were consumed by the register file upstream.
    assign w_unused_regidx = ^i_instruction[25:16];

    always_comb begin
        w_code    = ALU_ADD;
        o_signed  = 1'b0;
        o_first   = i_rs_data;
        o_second  = i_rt_data;
        o_illegal = 1'b0;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                FN_SLL:  begin w_code = ALU_SLL; o_first = i_rt_data; o_second = w_shamt;    end
                FN_SRL:  begin w_code = ALU_SRL; o_first = i_rt_data; o_second = w_shamt;    end
                FN_SRA:  begin w_code = ALU_SRA; o_first = i_rt_data; o_second = w_shamt;    end
                FN_SLLV: begin w_code = ALU_SLL; o_first = i_rt_data; o_second = w_rs_shamt; end
                FN_SRLV: begin w_code = ALU_SRL; o_first = i_rt_data; o_second = w_rs_shamt; end
                FN_SRAV: begin w_code = ALU_SRA; o_first = i_rt_data; o_second = w_rs_shamt; end
                FN_ADD:  begin w_code = ALU_ADD; o_signed = 1'b1; end
                FN_ADDU: w_code = ALU_ADD;
                FN_SUB:  begin w_code = ALU_SUB; o_signed = 1'b1; end
                FN_SUBU: w_code = ALU_SUB;
                FN_AND:  w_code = ALU_AND;
                FN_OR:   w_code = ALU_OR;
                FN_XOR:  w_code = ALU_XOR;
                FN_NOR:  w_code = ALU_NOR;
                FN_SLT:  w_code = ALU_SLT;
                default: o_illegal = 1'b1;
            endcase
        end else begin
            case (w_op)
                OP_ADDI:       begin w_code = ALU_ADD; o_signed = 1'b1; o_second = w_imm_sext; end
                OP_ADDIU:      begin w_code = ALU_ADD; o_second = w_imm_sext; end
                OP_SLTI:       begin w_code = ALU_SLT; o_second = w_imm_sext; end
                OP_ANDI:       begin w_code = ALU_AND; o_second = w_imm_zext; end
                OP_ORI:        begin w_code = ALU_OR;  o_second = w_imm_zext; end
                OP_XORI:       begin w_code = ALU_XOR; o_second = w_imm_zext; end
                OP_LUI:        begin w_code = ALU_OR;  o_first = '0; o_second = w_imm_upper; end
                OP_LW, OP_SW:  begin w_code = ALU_ADD; o_second = w_imm_sext; end
                OP_BEQ, OP_BNE: w_code = ALU_SUB;
                default:       o_illegal = 1'b1;
            endcase
        end
        // Illegal encodings leave a harmless ADD 0+0 in the slot.
        if (o_illegal) begin
            w_code   = ALU_ADD;
            o_signed = 1'b0;
            o_first  = '0;
            o_second = '0;
        end
    end

    assign o_opcode = NB_ALU_OPCODE'(w_code);

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode plus a valid/ready output register toward EX.
// ALU_ISSUE_SKID_EN adds a skid entry so o_ready is registered instead of combinational.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NB_DATA       = 32,
    parameter int NB_ALU_OPCODE = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NB_DATA-1:0]       i_instruction,
    input  logic [NB_DATA-1:0]       i_rs_data,
    input  logic [NB_DATA-1:0]       i_rt_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NB_DATA-1:0]       o_first_operator,
    output logic [NB_DATA-1:0]       o_second_operator,
    output logic [NB_ALU_OPCODE-1:0] o_opcode,
    output logic                     o_signed_operation,
    output logic                     o_illegal
);

    localparam int NB_ENTRY = 2*NB_DATA + NB_ALU_OPCODE + 2;

    logic [NB_ALU_OPCODE-1:0] w_dec_opcode;
    logic                     w_dec_signed;
    logic [NB_DATA-1:0]       w_dec_first;
    logic [NB_DATA-1:0]       w_dec_second;
    logic                     w_dec_illegal;
    logic [NB_ENTRY-1:0]      w_entry;
    logic                     w_accept;
    logic [NB_ENTRY-1:0]      r_out;
    logic                     r_valid;

    alu_issue_decode #(
        .NB_DATA       (NB_DATA),
        .NB_ALU_OPCODE (NB_ALU_OPCODE)
    ) u_decode (
        .i_instruction (i_instruction),
        .i_rs_data     (i_rs_data),
        .i_rt_data     (i_rt_data),
        .o_opcode      (w_dec_opcode),
        .o_signed      (w_dec_signed),
        .o_first       (w_dec_first),
        .o_second      (w_dec_second),
        .o_illegal     (w_dec_illegal)
    );

    assign w_entry = {w_dec_illegal, w_dec_signed, w_dec_opcode, w_dec_first, w_dec_second};
    assign {o_illegal, o_signed_operation, o_opcode, o_first_operator, o_second_operator} = r_out;
    assign o_valid = r_valid;

`ifdef ALU_ISSUE_SKID_EN
    logic [NB_ENTRY-1:0] r_skid;
    logic                r_skid_valid;
    logic                r_ready;
    logic                w_out_free;

    assign o_ready    = r_ready;
    assign w_accept   = i_valid && r_ready;
    assign w_out_free = !r_valid || i_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid      <= 1'b0;
            r_out        <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_ready      <= 1'b1;
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else if (w_out_free) begin
            // r_ready is low whenever the skid is full, so no accept competes with the refill.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
                r_ready      <= 1'b1;
            end else if (w_accept) begin
                r_out   <= w_entry;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_entry;
            r_skid_valid <= 1'b1;
            r_ready      <= 1'b0;
        end
    end
`else
    assign o_ready  = !r_valid || i_ready;
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_out   <= w_entry;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases plus random traffic against a queue model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
    logic [31:0] i_instruction = '0, i_rs_data = '0, i_rt_data = '0;
    logic        o_ready, o_valid, o_signed_operation, o_illegal;
    logic [31:0] o_first_operator, o_second_operator;
    logic [3:0]  o_opcode;

    always #5 clk = ~clk;

    alu_issue #(.NB_DATA(32), .NB_ALU_OPCODE(4)) dut (
        .i_clock            (clk),
        .i_reset            (i_reset),
        .i_flush            (i_flush),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_instruction      (i_instruction),
        .i_rs_data          (i_rs_data),
        .i_rt_data          (i_rt_data),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_first_operator   (o_first_operator),
        .o_second_operator  (o_second_operator),
        .o_opcode           (o_opcode),
        .o_signed_operation (o_signed_operation),
        .o_illegal          (o_illegal)
    );

    typedef struct {
        logic [3:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0, n_in = 0, n_out = 0;
    bit   armed = 0, zero_data = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected ALU request for one instruction, straight from the ISA table.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [31:0] sx = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] zx = {16'h0, ins[15:0]};
        logic [31:0] sh = {27'h0, ins[10:6]};
        logic [31:0] vs = {27'h0, rs[4:0]};
        exp_t e;
        e = '{op: 4'hC, sgn: 1'b0, a: 32'h0, b: 32'h0, ill: 1'b1};
        if (op == 6'h00) begin
            case (fn)
                6'h00: e = '{4'h0, 1'b0, rt, sh, 1'b0};
                6'h02: e = '{4'h2, 1'b0, rt, sh, 1'b0};
                6'h03: e = '{4'h3, 1'b0, rt, sh, 1'b0};
                6'h04: e = '{4'h0, 1'b0, rt, vs, 1'b0};
                6'h06: e = '{4'h2, 1'b0, rt, vs, 1'b0};
                6'h07: e = '{4'h3, 1'b0, rt, vs, 1'b0};
                6'h20: e = '{4'hC, 1'b1, rs, rt, 1'b0};
                6'h21: e = '{4'hC, 1'b0, rs, rt, 1'b0};
                6'h22: e = '{4'hB, 1'b1, rs, rt, 1'b0};
                6'h23: e = '{4'hB, 1'b0, rs, rt, 1'b0};
                6'h24: e = '{4'h4, 1'b0, rs, rt, 1'b0};
                6'h25: e = '{4'hD, 1'b0, rs, rt, 1'b0};
                6'h26: e = '{4'hE, 1'b0, rs, rt, 1'b0};
                6'h27: e = '{4'h7, 1'b0, rs, rt, 1'b0};
                6'h2A: e = '{4'h9, 1'b0, rs, rt, 1'b0};
                default: ;
            endcase
        end else begin
            case (op)
                6'h08: e = '{4'hC, 1'b1, rs, sx, 1'b0};
                6'h09: e = '{4'hC, 1'b0, rs, sx, 1'b0};
                6'h0A: e = '{4'h9, 1'b0, rs, sx, 1'b0};
                6'h0C: e = '{4'h4, 1'b0, rs, zx, 1'b0};
                6'h0D: e = '{4'hD, 1'b0, rs, zx, 1'b0};
                6'h0E: e = '{4'hE, 1'b0, rs, zx, 1'b0};
                6'h0F: e = '{4'hD, 1'b0, 32'h0, {ins[15:0], 16'h0}, 1'b0};
                6'h23, 6'h2B: e = '{4'hC, 1'b0, rs, sx, 1'b0};
                6'h04, 6'h05: e = '{4'hB, 1'b0, rs, rt, 1'b0};
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        case ($urandom % 4)
            0, 1: begin
                r[31:26] = 6'h00;
                case ($urandom % 16)
                    0: r[5:0] = 6'h00;  1: r[5:0] = 6'h02;  2: r[5:0] = 6'h03;  3: r[5:0] = 6'h04;
                    4: r[5:0] = 6'h06;  5: r[5:0] = 6'h07;  6: r[5:0] = 6'h20;  7: r[5:0] = 6'h21;
                    8: r[5:0] = 6'h22;  9: r[5:0] = 6'h23; 10: r[5:0] = 6'h24; 11: r[5:0] = 6'h25;
                    12: r[5:0] = 6'h26; 13: r[5:0] = 6'h27; 14: r[5:0] = 6'h2A; default: ;
                endcase
            end
            2: begin
                case ($urandom % 12)
                    0: r[31:26] = 6'h08; 1: r[31:26] = 6'h09; 2: r[31:26] = 6'h0A; 3: r[31:26] = 6'h0C;
                    4: r[31:26] = 6'h0D; 5: r[31:26] = 6'h0E; 6: r[31:26] = 6'h0F; 7: r[31:26] = 6'h23;
                    8: r[31:26] = 6'h2B; 9: r[31:26] = 6'h04; 10: r[31:26] = 6'h05; default: ;
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

    // Per-cycle compare, then advance the model by what the coming edge transfers.
    always @(negedge clk) begin
        if (armed) begin
            bit   mready;
            exp_t e;
`ifdef ALU_ISSUE_SKID_EN
            mready = (q.size() < 2);
`else
            mready = (q.size() == 0) || i_ready;
`endif
            chk("o_valid", o_valid, q.size() > 0);
            chk("o_ready", o_ready, mready);
            if (q.size() > 0) begin
                chk("opcode", o_opcode, q[0].op);
                chk("signed", o_signed_operation, q[0].sgn);
                chk("first", o_first_operator, q[0].a);
                chk("second", o_second_operator, q[0].b);
                chk("illegal", o_illegal, q[0].ill);
            end else if (zero_data) begin
                chk("reset_data", {o_opcode, o_signed_operation, o_illegal} | o_first_operator | o_second_operator, 0);
            end
            if (i_reset) begin
                q.delete();
                zero_data = 1;
            end else if (i_flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && i_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
                if (i_valid && mready) begin
                    e = model(i_instruction, i_rs_data, i_rt_data);
                    q.push_back(e);
                    zero_data = 0;
                    n_in++;
                end
            end
        end
    end

    task automatic send1(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        i_valid = 1'b1;
        i_instruction = ins;
        i_rs_data = rs;
        i_rt_data = rt;
        step();
        i_valid = 1'b0;
    endtask

    task automatic fill_stalled();
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_valid = 1'b1;
            i_instruction = rand_instr();
            i_rs_data = $urandom;
            i_rt_data = $urandom;
            step();
        end
        i_valid = 1'b0;
    endtask

    initial begin
        int acc, out0;
        step();
        armed = 1;
        step();
        i_reset = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);

        send1(32'h00221820, 32'd5, 32'hFFFFFFFE);
        chk("add_valid", o_valid, 1);
        chk("add_opcode", o_opcode, 4'b1100);
        chk("add_signed", o_signed_operation, 1);
        chk("add_first", o_first_operator, 32'd5);
        chk("add_second", o_second_operator, 32'hFFFFFFFE);

        send1(32'h00031103, 32'h1234_5678, 32'h80000000);
        chk("sra_opcode", o_opcode, 4'b0011);
        chk("sra_first", o_first_operator, 32'h80000000);
        chk("sra_second", o_second_operator, 32'd4);

        send1(32'h3C011234, 32'hDEADBEEF, 32'h0BADF00D);
        chk("lui_opcode", o_opcode, 4'b1101);
        chk("lui_first", o_first_operator, 32'h0);
        chk("lui_second", o_second_operator, 32'h12340000);

        send1(32'h30008000, 32'h1, 32'h2);
        chk("andi_second", o_second_operator, 32'h00008000);
        send1(32'h20008000, 32'h1, 32'h2);
        chk("addi_second", o_second_operator, 32'hFFFF8000);
        chk("addi_signed", o_signed_operation, 1);
        send1(32'hFC000000, 32'h55, 32'h66);
        chk("ill_flag", o_illegal, 1);
        chk("ill_first", o_first_operator, 0);
        chk("ill_second", o_second_operator, 0);

        // Backpressure: three instructions against four stalled cycles.
        i_ready = 1'b1;
        step();
        acc = 0;
        out0 = n_out;
        for (int c = 0; c < 30 && acc < 3; c++) begin
            i_valid = 1'b1;
            case (acc)
                0: i_instruction = 32'h00221820;
                1: i_instruction = 32'h00221822;
                default: i_instruction = 32'h00221826;
            endcase
            i_rs_data = $urandom;
            i_rt_data = $urandom;
            i_ready = (c >= 4);
            #3;
            if (c < 4) begin
`ifdef ALU_ISSUE_SKID_EN
                chk("bp_ready", o_ready, acc < 2);
`else
                chk("bp_ready", o_ready, acc < 1);
`endif
            end
            if (o_ready) acc++;
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) step();
        chk("bp_accepted", acc, 3);
        chk("bp_drained", n_out - out0, 3);

        // Flush with an incoming instruction on the same edge.
        fill_stalled();
        chk("fl_held", o_valid, 1);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_instruction = 32'h00221820;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("fl_valid", o_valid, 0);
        chk("fl_ready", o_ready, 1);
        i_ready = 1'b1;
        repeat (3) step();
        chk("fl_dropped", o_valid, 0);

        // Reset during a stall.
        fill_stalled();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("rs_valid", o_valid, 0);
        chk("rs_data", o_first_operator | o_second_operator, 0);
        chk("rs_opcode", o_opcode, 0);
        chk("rs_ready", o_ready, 1);
        send1(32'h00221820, 32'd7, 32'd9);
        chk("rs_reissue_valid", o_valid, 1);
        chk("rs_reissue_first", o_first_operator, 32'd7);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            i_valid = ($urandom % 4) != 0;
            i_ready = ($urandom % 3) != 0;
            i_flush = ($urandom % 40) == 0;
            i_reset = ($urandom % 250) == 0;
            i_instruction = rand_instr();
            i_rs_data = $urandom;
            i_rt_data = $urandom;
            step();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_reset = 1'b0;
        i_ready = 1'b1;
        repeat (4) step();
        chk("final_empty", o_valid, 0);
        chk("random_traffic", n_in > 500, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
